// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: FSM encoding,
// exception entry vector and the saturating counter helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_RUN   = 2'd0,
        PC_DRAIN = 2'd1,
        PC_FLUSH = 2'd2
    } pc_state_e;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
    localparam logic [5:0]  STALL_NONE = 6'b000000;
    localparam logic [5:0]  STALL_ALL  = 6'b111111;
    localparam logic        STOP       = 1'b1;
    localparam logic        NO_STOP    = 1'b0;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of stall requests, exception/bus status and the controller's
// outputs; the slave modport is the controller's view.
interface pipe_ctrl_if;

    logic        stallreq_ic;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        ex_req;
    logic        ex_is_eret;
    logic [31:0] cp0_epc;
    logic        ic_busy;
    logic        dc_busy;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        except_ack;
    logic [31:0] stall_cnt;

    modport master (
        output stallreq_ic, stallreq_id, stallreq_ex, stallreq_mem,
        output ex_req, ex_is_eret, cp0_epc, ic_busy, dc_busy,
        input  stall, flush, new_pc, except_ack, stall_cnt
    );

    modport slave (
        input  stallreq_ic, stallreq_id, stallreq_ex, stallreq_mem,
        input  ex_req, ex_is_eret, cp0_epc, ic_busy, dc_busy,
        output stall, flush, new_pc, except_ack, stall_cnt
    );

endinterface

// File: rtl/pipe_ctrl_stall_enc.sv
// Priority encoder: the deepest stalling stage freezes itself and every
// earlier stage, giving a prefix mask over pc..wb.
module pipe_stall_enc
    import pipe_ctrl_pkg::*;
(
    input  logic       stallreq_ic_i,
    input  logic       stallreq_id_i,
    input  logic       stallreq_ex_i,
    input  logic       stallreq_mem_i,
    output logic [5:0] stall_mask_o
);

    // Deepest request wins
    always_comb begin
        stall_mask_o = STALL_NONE;
        if (stallreq_mem_i) begin
            stall_mask_o = 6'b011111;
        end else if (stallreq_ex_i) begin
            stall_mask_o = 6'b001111;
        end else if (stallreq_id_i) begin
            stall_mask_o = 6'b000111;
        end else if (stallreq_ic_i) begin
            stall_mask_o = 6'b000011;
        end else begin
            stall_mask_o = STALL_NONE;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall requests, sequences exception/ERET
// entry (drain buses, one flush cycle with redirect PC), counts stall cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);

    pc_state_e   state_q, state_d;
    logic [31:0] target_q, target_d;
    logic [31:0] cnt_q, cnt_d;
    logic [5:0]  enc_mask_s;
    logic [5:0]  stall_s;
    logic        flush_s;
    logic        bus_idle_s;

    assign bus_idle_s = ~bus.ic_busy & ~bus.dc_busy;

    pipe_stall_enc u_stall_enc (
        .stallreq_ic_i  (bus.stallreq_ic),
        .stallreq_id_i  (bus.stallreq_id),
        .stallreq_ex_i  (bus.stallreq_ex),
        .stallreq_mem_i (bus.stallreq_mem),
        .stall_mask_o   (enc_mask_s)
    );

    // State, redirect target and stall counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= PC_RUN;
            target_q <= 32'd0;
            cnt_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and target capture; ex_req is only seen in RUN
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        case (state_q)
            PC_RUN: begin
                if (bus.ex_req) begin
                    target_d = bus.ex_is_eret ? bus.cp0_epc : EXC_VECTOR;
                    state_d  = bus_idle_s ? PC_FLUSH : PC_DRAIN;
                end else begin
                    state_d  = PC_RUN;
                end
            end
            PC_DRAIN: begin
                if (bus_idle_s) begin
                    state_d = PC_FLUSH;
                end else begin
                    state_d = PC_DRAIN;
                end
            end
            PC_FLUSH: state_d = PC_RUN;
            default:  state_d = PC_RUN;
        endcase
    end

    // Raw stall/flush per state; exception acceptance overrides requests
    always_comb begin
        stall_s = STALL_NONE;
        flush_s = 1'b0;
        case (state_q)
            PC_RUN: begin
                if (bus.ex_req) begin
                    stall_s = STALL_ALL;
                end else begin
                    stall_s = enc_mask_s;
                end
            end
            PC_DRAIN: stall_s = STALL_ALL;
            PC_FLUSH: flush_s = 1'b1;
            default: begin
                stall_s = STALL_NONE;
                flush_s = 1'b0;
            end
        endcase
    end

    // Saturating count of cycles where the pc stage is held
    always_comb begin
        if (stall_s[0] == STOP) begin
            cnt_d = sat_inc(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outputs are forced quiet while reset is asserted
    always_comb begin
        if (!rst) begin
            bus.stall      = STALL_NONE;
            bus.flush      = 1'b0;
            bus.except_ack = 1'b0;
            bus.new_pc     = 32'd0;
        end else begin
            bus.stall      = stall_s;
            bus.flush      = flush_s;
            bus.except_ack = flush_s;
            bus.new_pc     = target_q;
        end
    end

    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed test-plan scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if bus_if();

    pipe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int ack_seen = 0;

    // Model: exception pending on buses, flush cycle due, target, counter
    bit          m_wait;
    bit          m_flush;
    logic [31:0] m_target;
    logic [31:0] m_cnt;
    logic [5:0]  e_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] req_mask(input logic [3:0] reqs);
        int deepest = -1;
        for (int i = 0; i < 4; i++) begin
            if (reqs[i]) deepest = i;
        end
        if (deepest < 0) return 6'd0;
        return 6'((1 << (deepest + 2)) - 1);
    endfunction

    task automatic drive(input logic [3:0] reqs, input logic ex, input logic eret,
                         input logic [31:0] epc, input logic icb, input logic dcb);
        bus_if.stallreq_ic  = reqs[0];
        bus_if.stallreq_id  = reqs[1];
        bus_if.stallreq_ex  = reqs[2];
        bus_if.stallreq_mem = reqs[3];
        bus_if.ex_req       = ex;
        bus_if.ex_is_eret   = eret;
        bus_if.cp0_epc      = epc;
        bus_if.ic_busy      = icb;
        bus_if.dc_busy      = dcb;
    endtask

    // Let inputs settle and compare every output against the model
    task automatic settle();
        logic [3:0] reqs;
        #1;
        reqs = {bus_if.stallreq_mem, bus_if.stallreq_ex, bus_if.stallreq_id, bus_if.stallreq_ic};
        if (!rst)          e_stall = 6'd0;
        else if (m_flush)  e_stall = 6'd0;
        else if (m_wait)   e_stall = 6'h3F;
        else if (bus_if.ex_req) e_stall = 6'h3F;
        else               e_stall = req_mask(reqs);
        chk("stall", 32'(bus_if.stall), 32'(e_stall));
        chk("flush", 32'(bus_if.flush), 32'(rst && m_flush));
        chk("ack", 32'(bus_if.except_ack), 32'(rst && m_flush));
        chk("cnt", bus_if.stall_cnt, m_cnt);
        if (!rst) chk("new_pc_rst", bus_if.new_pc, 32'd0);
        else if (m_flush) chk("new_pc", bus_if.new_pc, m_target);
        if (bus_if.except_ack) ack_seen++;
    endtask

    // Advance one clock and update the model from the cycle's inputs
    task automatic tick();
        bit idle;
        idle = !bus_if.ic_busy && !bus_if.dc_busy;
        @(posedge clk);
        if (!rst) begin
            m_wait = 0; m_flush = 0; m_target = 32'd0; m_cnt = 32'd0;
        end else begin
            if (e_stall[0] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (m_flush) begin
                m_flush = 0;
            end else if (m_wait) begin
                if (idle) begin m_wait = 0; m_flush = 1; end
            end else if (bus_if.ex_req) begin
                m_target = bus_if.ex_is_eret ? bus_if.cp0_epc : 32'hBFC0_0380;
                if (idle) m_flush = 1; else m_wait = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    initial begin
        int acks_before;
        m_wait = 0; m_flush = 0; m_target = 32'd0; m_cnt = 32'd0;
        rst = 1'b0;
        drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        cycle();
        cycle();
        settle();
        chk("reset_cnt", bus_if.stall_cnt, 32'd0);
        tick();
        rst = 1'b1;

        // Priority encoding
        drive(4'b1010, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        settle(); chk("prio_mem_id", 32'(bus_if.stall), 32'h1F); tick();
        drive(4'b0001, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        settle(); chk("prio_ic", 32'(bus_if.stall), 32'h03); tick();
        drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        settle(); chk("prio_none", 32'(bus_if.stall), 32'h00); tick();

        // Exception with idle buses
        drive(4'b0000, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
        settle(); chk("exc_stall", 32'(bus_if.stall), 32'h3F); tick();
        drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        settle();
        chk("exc_flush", 32'(bus_if.flush), 32'd1);
        chk("exc_ack", 32'(bus_if.except_ack), 32'd1);
        chk("exc_pc", bus_if.new_pc, 32'hBFC0_0380);
        tick();
        settle(); chk("exc_flush_end", 32'(bus_if.flush), 32'd0); tick();

        // ERET with data bus busy; EPC changes during drain
        drive(4'b0000, 1'b1, 1'b1, 32'h8000_1234, 1'b0, 1'b1);
        settle(); chk("eret_accept", 32'(bus_if.stall), 32'h3F); tick();
        for (int i = 0; i < 4; i++) begin
            drive(4'b0100, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
            settle(); chk("eret_drain", 32'(bus_if.stall), 32'h3F); tick();
        end
        drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        settle(); chk("eret_idle", 32'(bus_if.flush), 32'd0); tick();
        settle(); chk("eret_pc", bus_if.new_pc, 32'h8000_1234);
        chk("eret_flush", 32'(bus_if.flush), 32'd1); tick();

        // ex_req with stallreq_ex, ex_req held across FLUSH
        acks_before = ack_seen;
        drive(4'b0100, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle();
        settle(); chk("sim_flush", 32'(bus_if.flush), 32'd1); tick();
        drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle();
        cycle();
        chk("one_ack", 32'(ack_seen - acks_before), 32'd1);

        // Reset mid-DRAIN
        drive(4'b0000, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        cycle();
        cycle();
        rst = 1'b0;
        settle();
        chk("rst_stall", 32'(bus_if.stall), 32'd0);
        chk("rst_flush", 32'(bus_if.flush), 32'd0);
        tick();
        settle(); chk("rst_cnt", bus_if.stall_cnt, 32'd0); tick();
        rst = 1'b1;
        drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle(); chk("post_rst", 32'(bus_if.stall), 32'd0); tick();
        end

        // Counter saturation
        force dut.cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFD;
        cycle();
        drive(4'b0001, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle();
        drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        settle(); chk("cnt_sat", bus_if.stall_cnt, 32'hFFFF_FFFF); tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) != 0);
            drive(4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), $urandom(),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
